// File: rtl/qk_mac_sequencer_pkg.sv
// Shared constants for the Q*K^T sequencer: array instruction codes and FSM state encodings.
package qk_mac_sequencer_pkg;

    localparam logic [1:0] InstIdle  = 2'b00;
    localparam logic [1:0] InstLoadK = 2'b01;
    localparam logic [1:0] InstExec  = 2'b10;

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StLoadK = 3'd1;
    localparam logic [2:0] StGap   = 3'd2;
    localparam logic [2:0] StExecQ = 3'd3;
    localparam logic [2:0] StDrain = 3'd4;
    localparam logic [2:0] StDone  = 3'd5;

    function automatic logic [1:0] inst_for_state(input logic [2:0] st);
        logic [1:0] inst;
        case (st)
            StLoadK: inst = InstLoadK;
            StExecQ: inst = InstExec;
            default: inst = InstIdle;
        endcase
        return inst;
    endfunction

endpackage

// File: rtl/qk_mac_sequencer_popcount_col.sv
// Combinational population count of the per-column psum write strobes.
module qk_mac_sequencer_popcount_col #(
    parameter int unsigned Col = 8
) (
    input  logic [Col-1:0]             fifo_wr_i,
    output logic [$clog2(Col+1)-1:0]   count_o
);

    always_comb begin
        count_o = '0;
        for (int i = 0; i < Col; i++) begin
            count_o = count_o + ($clog2(Col+1))'(fifo_wr_i[i]);
        end
    end

endmodule

// File: rtl/qk_mac_sequencer.sv
// Drives one mac_array through a K load, settle gap, Q stream and psum drain from one SRAM port.
module qk_mac_sequencer
    import qk_mac_sequencer_pkg::*;
#(
    parameter int unsigned Col  = 8,
    parameter int unsigned Bw   = 8,
    parameter int unsigned Pr   = 8,
    parameter int unsigned Aw   = 8,
    parameter int unsigned QMax = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [Aw-1:0]    k_base,
    input  logic [Aw-1:0]    q_base,
    input  logic [4:0]       num_q,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             mem_ren,
    output logic [Aw-1:0]    mem_addr,
    input  logic [Bw*Pr-1:0] mem_rdata,
    output logic [Bw*Pr-1:0] mac_in,
    output logic [1:0]       mac_inst,
    input  logic [Col-1:0]   mac_fifo_wr
);

    localparam int unsigned GapCyc  = Col + Pr + 5;
    localparam int unsigned DrainTo = Col + QMax + Pr + 8;
    localparam int unsigned CntMax  = (GapCyc > QMax) ? GapCyc : QMax;
    localparam int unsigned CntW    = $clog2(CntMax + 1);
    localparam int unsigned DrainW  = $clog2(DrainTo + 1);
    // One spare bit so a final beat of excess strobes cannot wrap the count.
    localparam int unsigned PsumW   = $clog2(Col * QMax + 1) + 1;
    localparam int unsigned PopW    = $clog2(Col + 1);

    logic [2:0]        state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [Aw-1:0]     k_base_q, k_base_d;
    logic [Aw-1:0]     q_base_q, q_base_d;
    logic [4:0]        num_q_q, num_q_d;
    logic [PsumW-1:0]  psum_q, psum_d;
    logic [DrainW-1:0] drain_q, drain_d;
    logic              timeout_q, timeout_d;
    logic [1:0]        inst_q;
    logic [PopW-1:0]   pop;
    logic [PsumW-1:0]  target;
    logic              start_ok;

    qk_mac_sequencer_popcount_col #(
        .Col (Col)
    ) u_popcount (
        .fifo_wr_i (mac_fifo_wr),
        .count_o   (pop)
    );

    assign start_ok = start && (num_q != 5'd0) && (32'(num_q) <= QMax);
    assign target   = PsumW'(Col) * PsumW'(num_q_q);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        k_base_d  = k_base_q;
        q_base_d  = q_base_q;
        num_q_d   = num_q_q;
        psum_d    = psum_q;
        drain_d   = drain_q;
        timeout_d = timeout_q;

        if ((state_q == StExecQ || state_q == StDrain) && psum_q < target) begin
            psum_d = psum_q + PsumW'(pop);
        end

        case (state_q)
            StIdle: begin
                if (start_ok) begin
                    k_base_d  = k_base;
                    q_base_d  = q_base;
                    num_q_d   = num_q;
                    cnt_d     = '0;
                    psum_d    = '0;
                    drain_d   = '0;
                    timeout_d = 1'b0;
                    state_d   = StLoadK;
                end
            end
            StLoadK: begin
                if (cnt_q == CntW'(Col - 1)) begin
                    cnt_d   = '0;
                    state_d = StGap;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StGap: begin
                if (cnt_q == CntW'(GapCyc - 1)) begin
                    cnt_d   = '0;
                    state_d = StExecQ;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StExecQ: begin
                if (cnt_q == CntW'(num_q_q) - CntW'(1)) begin
                    cnt_d   = '0;
                    drain_d = '0;
                    state_d = StDrain;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDrain: begin
                // Strobes landing this cycle already count towards completion.
                if (psum_d >= target) begin
                    state_d = StDone;
                end else if (drain_q == DrainW'(DrainTo - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = StDone;
                end else begin
                    drain_d = drain_q + DrainW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            k_base_q  <= '0;
            q_base_q  <= '0;
            num_q_q   <= '0;
            psum_q    <= '0;
            drain_q   <= '0;
            timeout_q <= 1'b0;
            inst_q    <= InstIdle;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            k_base_q  <= k_base_d;
            q_base_q  <= q_base_d;
            num_q_q   <= num_q_d;
            psum_q    <= psum_d;
            drain_q   <= drain_d;
            timeout_q <= timeout_d;
            inst_q    <= inst_for_state(state_q);
        end
    end

    assign busy     = (state_q == StLoadK) || (state_q == StGap) ||
                      (state_q == StExecQ) || (state_q == StDrain);
    assign done     = (state_q == StDone);
    assign err      = done && timeout_q;
    assign mem_ren  = (state_q == StLoadK) || (state_q == StExecQ);
    assign mac_inst = inst_q;
    assign mac_in   = (inst_q != InstIdle) ? mem_rdata : '0;

    always_comb begin
        mem_addr = '0;
        if (state_q == StLoadK) begin
            mem_addr = k_base_q + Aw'(cnt_q);
        end else if (state_q == StExecQ) begin
            mem_addr = q_base_q + Aw'(cnt_q);
        end
    end

endmodule
